// File: rtl/ntsc_zbt_packer_pkg.sv
// Shared types for the NTSC-to-ZBT write path: capture modes, default bus widths, queue entry.
package ntsc_pkg;

    typedef enum logic [1:0] {
        MODE_PACK  = 2'd0,
        MODE_REPL  = 2'd1,
        MODE_DECIM = 2'd2,
        MODE_RSVD  = 2'd3
    } mode_e;

    localparam int unsigned ZBT_ADDR_W = 19;
    localparam int unsigned ZBT_WORD_W = 36;

    typedef struct packed {
        logic [ZBT_ADDR_W-1:0] addr;
        logic [ZBT_WORD_W-1:0] data;
    } zbt_entry_t;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/ntsc_zbt_packer_if.sv
// Write-request bus from the packer queue to the ZBT arbiter.
interface ntsc_zbt_packer_if #(
    parameter int unsigned ADDR_W = 19,
    parameter int unsigned WORD_W = 36
) ();
    logic [ADDR_W-1:0] mem_addr;
    logic [WORD_W-1:0] mem_data;
    logic              mem_req;
    logic              mem_ack;

    modport master (output mem_addr, output mem_data, output mem_req, input mem_ack);
    modport slave  (input mem_addr, input mem_data, input mem_req, output mem_ack);
endinterface

// File: rtl/ntsc_zbt_packer_fifo.sv
// Show-ahead write queue; head reads as zero while empty.
module zbt_wr_fifo
    import ntsc_pkg::*;
#(
    parameter int unsigned WIDTH = 55,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int unsigned PTR_W = clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_pop  = pop && !empty;
    // A pop frees the slot in the same cycle, so a push into a full queue still lands.
    assign do_push = push && (!full || do_pop);
    assign head    = empty ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + (PTR_W + 1)'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + (PTR_W + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= push_data;
    end
endmodule

// File: rtl/ntsc_zbt_packer.sv
// Crops a luma stream to a window, packs pixels into ZBT words and queues them for the arbiter.
module ntsc_zbt_packer
    import ntsc_pkg::*;
#(
    parameter int unsigned PIXEL_W      = 8,
    parameter int unsigned PIX_PER_WORD = 4,
    parameter int unsigned WORD_W       = ZBT_WORD_W,
    parameter int unsigned ADDR_W       = ZBT_ADDR_W,
    parameter int unsigned ROW_BITS     = 9,
    parameter int unsigned COL_BITS     = 10,
    parameter int unsigned COL_START    = 30,
    parameter int unsigned ROW_START    = 30,
    parameter int unsigned MAX_COLS     = 1024,
    parameter int unsigned MAX_ROWS     = 768,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         fvh,
    input  logic               pix_valid,
    input  logic [PIXEL_W-1:0] pix_data,
    input  logic [1:0]         mode,
    ntsc_zbt_packer_if.master  mem,
    output logic               overflow,
    output logic [15:0]        drop_count
);
    localparam int unsigned LOG_PPW = clog2(PIX_PER_WORD);
    localparam int unsigned LANE_W  = (LOG_PPW > 0) ? LOG_PPW : 1;
    localparam int unsigned PACK_W  = PIXEL_W * PIX_PER_WORD;
    localparam int unsigned ACOL_W  = COL_BITS - LOG_PPW;
    localparam int unsigned COL_W   = COL_BITS + 1;
    localparam int unsigned ROW_W   = (clog2(MAX_ROWS + 1) > ROW_BITS + 1) ?
                                      clog2(MAX_ROWS + 1) : ROW_BITS + 1;
    localparam int unsigned ENTRY_W = ADDR_W + WORD_W;

    logic [1:0]        sync_q;
    logic              armed_q;
    mode_e             mode_q;
    logic [COL_W-1:0]  col_q;
    logic [ROW_W-1:0]  row_q;
    logic [LANE_W-1:0] lane_q, lane_d;
    logic [PACK_W-1:0] word_q, word_d, word_fill, push_word;
    logic [ADDR_W-1:0] addr_q, addr_d, pix_addr, word_addr, push_addr;
    logic              overflow_q;
    logic [15:0]       drop_count_q;

    logic              vs_rise, hs_rise, active, keep, push, pop, drop, full, empty;
    logic [ENTRY_W-1:0] head;
    logic [ROW_BITS-1:0] a_row;
    logic              a_field;
    logic [ACOL_W-1:0] a_col;

    assign vs_rise = fvh[1] & ~sync_q[1];
    assign hs_rise = fvh[0] & ~sync_q[0];
    assign active  = armed_q & pix_valid & ~fvh[1] & ~fvh[0] &
                     (col_q < COL_W'(MAX_COLS)) & (row_q < ROW_W'(MAX_ROWS));
    assign keep    = (mode_q != MODE_DECIM) | (~col_q[0] & ~row_q[0]);

    // Word address from the current pixel position; decimation halves both axes and drops field.
    always_comb begin
        a_row   = row_q[ROW_BITS-1:0];
        a_field = fvh[2];
        a_col   = col_q[COL_BITS-1:LOG_PPW];
        case (mode_q)
            MODE_REPL: a_col = col_q[ACOL_W-1:0];
            MODE_DECIM: begin
                a_row   = row_q[ROW_BITS:1];
                a_field = 1'b0;
                a_col   = col_q[COL_BITS:LOG_PPW+1];
            end
            default: ;
        endcase
        pix_addr = ADDR_W'({a_row, a_field, a_col});
    end

    always_comb begin
        lane_d    = lane_q;
        word_d    = word_q;
        addr_d    = addr_q;
        push      = 1'b0;
        push_addr = addr_q;
        push_word = word_q;
        word_addr = (lane_q == '0) ? pix_addr : addr_q;
        word_fill = word_q;
        for (int unsigned i = 0; i < PIX_PER_WORD; i++) begin
            if (LANE_W'(i) == lane_q) word_fill[(PIX_PER_WORD-1-i)*PIXEL_W +: PIXEL_W] = pix_data;
        end
        if (vs_rise || hs_rise) begin
            push   = (lane_q != '0);
            lane_d = '0;
            word_d = '0;
        end else if (active && keep) begin
            if (mode_q == MODE_REPL) begin
                push      = 1'b1;
                push_addr = pix_addr;
                push_word = {PIX_PER_WORD{pix_data}};
            end else if (lane_q == LANE_W'(PIX_PER_WORD - 1)) begin
                push      = 1'b1;
                push_addr = word_addr;
                push_word = word_fill;
                lane_d    = '0;
                word_d    = '0;
            end else begin
                lane_d = lane_q + LANE_W'(1);
                word_d = word_fill;
                addr_d = word_addr;
            end
        end
    end

    assign pop  = ~empty & mem.mem_ack;
    assign drop = push & full & ~pop;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= '0;
            armed_q      <= 1'b0;
            mode_q       <= MODE_PACK;
            col_q        <= '0;
            row_q        <= '0;
            lane_q       <= '0;
            word_q       <= '0;
            addr_q       <= '0;
            overflow_q   <= 1'b0;
            drop_count_q <= '0;
        end else begin
            sync_q <= fvh[1:0];
            if (vs_rise) begin
                armed_q <= 1'b1;
                mode_q  <= (mode_e'(mode) == MODE_RSVD) ? MODE_PACK : mode_e'(mode);
                row_q   <= ROW_W'(ROW_START);
                col_q   <= COL_W'(COL_START);
            end else if (hs_rise) begin
                col_q <= COL_W'(COL_START);
                if (row_q < ROW_W'(MAX_ROWS)) row_q <= row_q + ROW_W'(1);
            end else if (active) begin
                col_q <= col_q + COL_W'(1);
            end
            lane_q <= lane_d;
            word_q <= word_d;
            addr_q <= addr_d;
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_count_q != 16'hFFFF) drop_count_q <= drop_count_q + 16'd1;
            end
        end
    end

    zbt_wr_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data ({push_addr, WORD_W'(push_word)}),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .head      (head)
    );

    assign mem.mem_req  = ~empty;
    assign mem.mem_addr = head[ENTRY_W-1:WORD_W];
    assign mem.mem_data = head[WORD_W-1:0];
    assign overflow     = overflow_q;
    assign drop_count   = drop_count_q;
endmodule

// File: doc/ntsc_zbt_packer.md
Name: ntsc_zbt_packer

Overview:
Parametrised successor to the NTSC-to-ZBT write path. Takes a decoded luma pixel stream with fvh sync flags, already in the system clock domain, and crops it to a window. Packs PIX_PER_WORD pixels per ZBT word and computes the word address from the first pixel of each word, so a line's left edge lands at word column 0. Queues completed words in a small FIFO that drains through a req/ack handshake to the ZBT arbiter. Adds three capture modes, line-end flush of partial words, and overflow accounting.

Parameters:
PIXEL_W, 8, bits per pixel
PIX_PER_WORD, 4, pixels per memory word (power of 2, PIXEL_W*PIX_PER_WORD <= WORD_W)
WORD_W, 36, ZBT data width; unused MSBs driven 0
ADDR_W, 19, ZBT address width
ROW_BITS, 9, row bits placed in the address
COL_BITS, 10, column counter width
COL_START, 30, column value loaded at line start
ROW_START, 30, row value loaded at frame start
MAX_COLS, 1024, columns >= this are discarded
MAX_ROWS, 768, rows >= this are discarded
FIFO_DEPTH, 8, write-queue entries (power of 2)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
fvh  in  3  [2]=field, [1]=vsync, [0]=hsync, synchronous to clk
pix_valid  in  1  one-cycle strobe: pix_data is a new pixel
pix_data  in  PIXEL_W  luma sample
mode  in  2  0=PACK, 1=REPLICATE, 2=DECIMATE, 3=reserved (behaves as PACK)
mem_addr  out  ADDR_W  head-of-queue address
mem_data  out  WORD_W  head-of-queue data
mem_req  out  1  queue non-empty
mem_ack  in  1  arbiter consumed head this cycle (ignored when mem_req=0)
overflow  out  1  sticky: a word was dropped
drop_count  out  16  saturating count of dropped words

Behaviour:
- Reset: all counters, lane index, and FIFO pointers clear; mem_req=0, mem_addr=0, mem_data=0, overflow=0, drop_count=0, armed=0. Reset mid-line discards the partial word.
- armed sets on the first vsync rising edge after reset; pixels are ignored until then.
- Active pixel = armed & pix_valid & !fvh[1] & !fvh[0] & col<MAX_COLS & row<MAX_ROWS.
- hsync rising edge: col<=COL_START, row<=row+1 (saturate at MAX_ROWS), flush any partial word. vsync rising edge: row<=ROW_START, col<=COL_START, flush. Each active pixel increments col.
- mode is sampled at every vsync rising edge; it does not change mid-frame.
- PACK: lane 0 (first pixel) occupies the MSB lane. The address is latched at lane 0: {zero pad, row[ROW_BITS-1:0], field, col[COL_BITS-1:log2(PIX_PER_WORD)]}. The word is pushed in the cycle of the last lane.
- REPLICATE: each active pixel produces one word with pix_data in every lane. Address = {pad, row, field, col[COL_BITS-log2(PPW)-1:0]}.
- DECIMATE: only pixels with even col and even row are kept. Packing is as in PACK. The field bit is replaced by 0, and the address uses col>>1 and row>>1.
- Flush: a partial word is pushed with unfilled lanes = 0, using its latched address. A flush is a no-op if the lane index is 0.
- Latency: the push occurs in the cycle of the last lane (or the flush); the entry is visible on mem_req/mem_addr/mem_data in the next cycle.
- FIFO: show-ahead. Pop = mem_req & mem_ack.
  - Push and pop in the same cycle when full: both succeed.
  - Push when full without pop: the word is dropped, overflow<=1, drop_count<=drop_count+1 (saturating at 16'hFFFF).
  - Push and pop when empty: the entry appears next cycle as normal.
- A flush coinciding with the last-lane push of the same word is a single push.

Decomposition:
- Package ntsc_pkg: mode encodings (MODE_PACK, MODE_REPL, MODE_DECIM), a clog2 function, and a FIFO entry type {addr, data}.
- Sub-module zbt_wr_fifo: parametrised by width and FIFO_DEPTH, with push, pop, full, empty, and show-ahead head output.
- The packer, counters, and address generation stay in the top level.

Test Plan:
- PACK, COL_START=0, ROW_START=0: vsync, hsync, then pixels 11,22,33,44 on row 0, field 0 -> one entry, addr=0, data=36'h0_11223344, mem_req rises the cycle after pixel 44.
- PACK: 6 pixels 11..66 then hsync -> entries (addr 0, 11223344) and (addr 1, 55660000).
- REPLICATE: pixel AB at col 5, row 2, field 1 -> addr {pad,9'd2,1'b1,8'd5}, data 36'h0_ABABABAB.
- DECIMATE: row 0 pixels 00..07 -> one word 00020406 at addr 0. Row 1 -> no entries.
- Overflow: mem_ack held 0, 9 words pushed -> 8 queued, overflow=1, drop_count=1. Then ack held 1 -> 8 pops in address order, then mem_req=0.
- Reset asserted after 2 pixels of a word -> no entry. Pixels before the next vsync are ignored. Capture resumes correctly after vsync.
